// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART rx/tx and the ALU: decodes header/value byte pairs into A, B, OP
// and returns the ALU result over tx after each OP write. Optional watchdog: CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int unsigned          NB_DATA        = 8,
  parameter int unsigned          NB_OP          = 6,
  parameter logic [NB_DATA-1:0]   HDR_A          = 8'h08,
  parameter logic [NB_DATA-1:0]   HDR_B          = 8'h10,
  parameter logic [NB_DATA-1:0]   HDR_OP         = 8'h20,
  parameter int unsigned          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err,
  output logic [2:0]         o_state_dbg
);

  // Handshakes are single-cycle strobes with no back-pressure: i_rx_done qualifies
  // i_rx_data for exactly one cycle, o_tx_start launches o_tx_data (held until
  // i_tx_done), and i_tx_done closes the transmission.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VAL = 3'd1,
    ST_EXEC     = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_TX  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_A    = 2'd1,
    FLD_B    = 2'd2,
    FLD_OP   = 2'd3
  } field_e;

  state_e             state_q, state_d;
  field_e             pend_q, pend_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               timeout;

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             in_wait;

  assign in_wait = (state_q == ST_WAIT_VAL) || (state_q == ST_WAIT_TX);
  assign timeout = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restarts on every state entry so each wait gets the full budget.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || !in_wait) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == HDR_A) begin
            pend_d  = FLD_A;
            state_d = ST_WAIT_VAL;
          end else if (i_rx_data == HDR_B) begin
            pend_d  = FLD_B;
            state_d = ST_WAIT_VAL;
          end else if (i_rx_data == HDR_OP) begin
            pend_d  = FLD_OP;
            state_d = ST_WAIT_VAL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT_VAL: begin
        // The value byte is taken verbatim, even if it looks like a header.
        if (i_rx_done) begin
          pend_d  = FLD_NONE;
          state_d = ST_IDLE;
          case (pend_q)
            FLD_A:   data_a_d = i_rx_data;
            FLD_B:   data_b_d = i_rx_data;
            FLD_OP: begin
              op_d    = i_rx_data[NB_OP-1:0];
              state_d = ST_EXEC;
            end
            default: err_d = 1'b1;
          endcase
        end else if (timeout) begin
          pend_d  = FLD_NONE;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        tx_data_d = i_alu_result;
        err_d     = i_rx_done;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        err_d   = i_rx_done;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        err_d = i_rx_done;
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        pend_d  = FLD_NONE;
        state_d = ST_IDLE;
      end
    endcase

    tx_start_d = (state_d == ST_SEND);
    busy_d     = (state_d == ST_EXEC) || (state_d == ST_SEND) || (state_d == ST_WAIT_TX);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= FLD_NONE;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_data_a    = data_a_q;
  assign o_data_b    = data_b_q;
  assign o_op        = op_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_state_dbg = state_q;

endmodule
